// File: rtl/char_transmitter_pkg.sv
// Shared definitions for the character link: FSM state encoding,
// character width and the constants also used by the far-end receiver.
package char_transmitter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int CHAR_W               = 8;
  localparam int CHAR_SPACE           = 27;
  localparam int DEFAULT_CLKS_PER_BIT = 10417;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/char_fifo.sv
// Synchronous FIFO buffering characters between the Morse decoder and
// the serializer. Push is ignored when full, pop is ignored when empty.
// Read data is the entry at the read pointer (show-ahead).
module char_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // Occupancy after this cycle's push and pop; a simultaneous pair cancels.
  always_comb begin
    count_d = count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage array is data only and is not reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/char_transmitter.sv
// UART serializer feeding the XBee radio: 1 start bit, 8 data bits LSB
// first, stop bit(s), CLKS_PER_BIT clocks per bit, characters buffered in
// char_fifo. Build option CHAR_TX_STOP2_EN stretches the stop bit to two
// bit-times; back-to-back frames still follow with no idle gap.
module char_transmitter
  import char_transmitter_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              cclk,
  input  logic              rstb,
  input  logic [CHAR_W-1:0] char_in,
  input  logic              char_valid,
  output logic              char_ready,
  output logic              tx_out,
  output logic              busy
);

  localparam int               CNT_W    = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_e         state_q;
  logic [CNT_W-1:0]  cyc_q;
  logic [2:0]        bit_idx_q;
  logic [CHAR_W-1:0] shift_q;
  logic              tx_q;

  logic              fifo_full;
  logic              fifo_empty;
  logic [CHAR_W-1:0] fifo_data;
  logic              bit_end;
  logic              last_stop;
  logic              pop;

  char_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CHAR_W)
  ) u_fifo (
    .clk_i   (cclk),
    .rst_n_i (rstb),
    .push_i  (char_valid),
    .data_i  (char_in),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bit_end = (cyc_q == CNT_LAST);

`ifdef CHAR_TX_STOP2_EN
  // bit_idx_q counts the stop bit-times: the frame ends on the second one.
  assign last_stop = bit_idx_q[0];
`else
  assign last_stop = 1'b1;
`endif

  // Pop when idle, or at the very end of the stop interval so the next
  // start bit follows the stop bit directly.
  assign pop = ~fifo_empty &
               ((state_q == ST_IDLE) |
                ((state_q == ST_STOP) & bit_end & last_stop));

  assign char_ready = ~fifo_full;
  assign busy       = (state_q != ST_IDLE) | ~fifo_empty;
  assign tx_out     = tx_q;

  // Frame sequencer; tx_q registers the current state's line level, so the
  // pin lags the state by one clock and never glitches.
  always_ff @(posedge cclk) begin
    if (!rstb) begin
      state_q   <= ST_IDLE;
      cyc_q     <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            state_q   <= ST_START;
            cyc_q     <= '0;
            bit_idx_q <= '0;
          end
        end
        ST_START: begin
          tx_q <= 1'b0;
          if (bit_end) begin
            state_q   <= ST_DATA;
            cyc_q     <= '0;
            bit_idx_q <= '0;
          end else begin
            cyc_q <= cyc_q + CNT_W'(1);
          end
        end
        ST_DATA: begin
          tx_q <= shift_q[bit_idx_q];
          if (bit_end) begin
            cyc_q <= '0;
            if (bit_idx_q == 3'd7) begin
              state_q   <= ST_STOP;
              bit_idx_q <= '0;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cyc_q <= cyc_q + CNT_W'(1);
          end
        end
        ST_STOP: begin
          tx_q <= 1'b1;
          if (bit_end) begin
            cyc_q <= '0;
            if (!last_stop) begin
              bit_idx_q <= 3'd1;
            end else begin
              bit_idx_q <= '0;
              state_q   <= pop ? ST_START : ST_IDLE;
            end
          end else begin
            cyc_q <= cyc_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  // Capture the popped character for serialisation.
  always_ff @(posedge cclk) begin
    if (pop) shift_q <= fifo_data;
  end

endmodule

// File: tb/tb_char_transmitter.sv
// Self-checking bench for char_transmitter (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Honours CHAR_TX_STOP2_EN for the expected frame length.
module tb_char_transmitter;
  import char_transmitter_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef CHAR_TX_STOP2_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME_CYC = CPB * NB;

  logic       cclk;
  logic       rstb;
  logic [7:0] char_in;
  logic       char_valid;
  logic       char_ready;
  logic       tx_out;
  logic       busy;

  char_transmitter #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .cclk       (cclk),
    .rstb       (rstb),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  initial cclk = 1'b0;
  always #5 cclk = ~cclk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0]  ch;
    logic [10:0] frame;   // line level per bit-time, index 0 = start bit
  } vec_t;

  vec_t       vecs [6];
  logic [7:0] rx_q [$];

  // serial decoder state
  logic       mon_active;
  int         mon_cnt;
  int         mon_k;
  logic [7:0] mon_byte;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge cclk);
    #1;
  endtask

  // Called at the sample point where the frame's start bit is first on the line.
  task automatic expect_frame(input string name, input logic [10:0] frame);
    for (int i = 0; i < NB; i++) begin
      for (int c = 0; c < CPB; c++) begin
        check($sformatf("%s bit%0d cyc%0d", name, i, c), {31'd0, tx_out}, {31'd0, frame[i]});
        step();
      end
    end
  endtask

  // Mid-bit UART decoder, sampled on the falling edge.
  initial begin
    mon_active = 1'b0;
    mon_cnt    = 0;
    mon_k      = 0;
    mon_byte   = '0;
    forever begin
      @(negedge cclk);
      if (rstb !== 1'b1) begin
        mon_active = 1'b0;
      end else if (!mon_active) begin
        if (tx_out === 1'b0) begin
          mon_active = 1'b1;
          mon_cnt    = 0;
        end
      end else begin
        mon_cnt++;
        if ((mon_cnt % CPB) == (CPB / 2)) begin
          mon_k = mon_cnt / CPB;
          if (mon_k == 0) begin
            check("rx start level", {31'd0, tx_out}, 32'd0);
          end else if (mon_k <= 8) begin
            mon_byte[mon_k-1] = tx_out;
          end else begin
            check("rx stop level", {31'd0, tx_out}, 32'd1);
            rx_q.push_back(mon_byte);
            mon_active = 1'b0;
          end
        end
      end
    end
  end

  logic [7:0] b2b_ch [3];
  logic [10:0] b2b_fr [3];
  logic [7:0] full_ch [6];
  int         acc_cyc [6];
  int         k;
  int         cyc;
  logic       rdy;

  initial begin
    vecs[0] = '{8'h41,             11'b11_0100_0001_0};
    vecs[1] = '{8'h00,             11'b11_0000_0000_0};
    vecs[2] = '{8'(CHAR_SPACE),    11'b11_0001_1011_0};
    vecs[3] = '{8'd25,             11'b11_0001_1001_0};
    vecs[4] = '{8'hFF,             11'b11_1111_1111_0};
    vecs[5] = '{8'hA5,             11'b11_1010_0101_0};
    for (int i = 0; i < 6; i++) full_ch[i] = 8'h30 + 8'(i);

    // Reset held 3 cycles with char_valid asserted
    rstb       = 1'b0;
    char_valid = 1'b1;
    char_in    = 8'h55;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("reset tx_out %0d", i), {31'd0, tx_out}, 32'd1);
      check($sformatf("reset busy %0d", i), {31'd0, busy}, 32'd0);
      check($sformatf("reset char_ready %0d", i), {31'd0, char_ready}, 32'd1);
    end
    rstb       = 1'b1;
    char_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check("post-reset idle tx", {31'd0, tx_out}, 32'd1);
    end
    check("post-reset busy", {31'd0, busy}, 32'd0);
    check("post-reset rx count", rx_q.size(), 32'd0);

    // Table: single characters into an idle transmitter
    for (int v = 0; v < 6; v++) begin
      rx_q.delete();
      char_in    = vecs[v].ch;
      char_valid = 1'b1;
      step();                                   // edge t: accepted
      char_valid = 1'b0;
      check($sformatf("v%0d busy after push", v), {31'd0, busy}, 32'd1);
      check($sformatf("v%0d tx high t", v), {31'd0, tx_out}, 32'd1);
      step();                                   // edge t+1: popped, line still idle
      check($sformatf("v%0d tx high t+1", v), {31'd0, tx_out}, 32'd1);
      step();                                   // edge t+2: start bit
      expect_frame($sformatf("v%0d", v), vecs[v].frame);
      check($sformatf("v%0d tx idle after", v), {31'd0, tx_out}, 32'd1);
      check($sformatf("v%0d busy after", v), {31'd0, busy}, 32'd0);
      check($sformatf("v%0d rx byte", v), (rx_q.size() > 0) ? {24'd0, rx_q[0]} : 32'hFFFF_FFFF,
            {24'd0, vecs[v].ch});
    end

    // Back-to-back: three pushes on consecutive edges, frames with no gap
    rx_q.delete();
    b2b_ch[0] = vecs[1].ch; b2b_fr[0] = vecs[1].frame;
    b2b_ch[1] = vecs[2].ch; b2b_fr[1] = vecs[2].frame;
    b2b_ch[2] = vecs[3].ch; b2b_fr[2] = vecs[3].frame;
    char_valid = 1'b1;
    char_in    = b2b_ch[0];
    step();
    char_in = b2b_ch[1];
    step();
    char_in = b2b_ch[2];
    step();
    char_valid = 1'b0;
    for (int f = 0; f < 3; f++) expect_frame($sformatf("b2b%0d", f), b2b_fr[f]);
    check("b2b tx idle after", {31'd0, tx_out}, 32'd1);
    check("b2b busy after", {31'd0, busy}, 32'd0);
    check("b2b rx count", rx_q.size(), 32'd3);
    for (int f = 0; f < 3; f++)
      check($sformatf("b2b rx byte%0d", f),
            (rx_q.size() > f) ? {24'd0, rx_q[f]} : 32'hFFFF_FFFF, {24'd0, b2b_ch[f]});

    // Full FIFO: valid held high for six characters
    rx_q.delete();
    k   = 0;
    cyc = 0;
    char_valid = 1'b1;
    char_in    = full_ch[0];
    while (k < 6 && cyc < 400) begin
      rdy = char_ready;
      step();
      cyc++;
      if (rdy) begin
        acc_cyc[k] = cyc;
        k++;
        if (k == 5) check("full ready low after 5th", {31'd0, char_ready}, 32'd0);
        if (k < 6) char_in = full_ch[k];
        else       char_valid = 1'b0;
      end
    end
    char_valid = 1'b0;
    check("full accepted count", k, 32'd6);
    for (int i = 0; i < 6; i++)
      check($sformatf("full accept cycle %0d", i), (i < k) ? acc_cyc[i] : -1,
            (i < 5) ? i + 1 : FRAME_CYC + 3);
    for (int i = 0; i < 8 * FRAME_CYC && rx_q.size() < 6; i++) step();
    check("full rx count", rx_q.size(), 32'd6);
    for (int i = 0; i < 6; i++)
      check($sformatf("full rx byte%0d", i),
            (rx_q.size() > i) ? {24'd0, rx_q[i]} : 32'hFFFF_FFFF, {24'd0, full_ch[i]});
    for (int i = 0; i < 2 * CPB && busy; i++) step();
    check("full busy after", {31'd0, busy}, 32'd0);

    // Mid-frame reset during data bit 3 with two characters queued
    rx_q.delete();
    char_valid = 1'b1;
    char_in    = 8'h07;
    step();                                     // edge t
    char_in = 8'h11;
    step();                                     // edge t+1
    char_in = 8'h22;
    step();                                     // edge t+2
    char_valid = 1'b0;
    for (int i = 0; i < 16; i++) step();        // edge t+18: data bit 3
    check("midrst bit3 level", {31'd0, tx_out}, 32'd0);
    check("midrst busy before", {31'd0, busy}, 32'd1);
    check("midrst ready before", {31'd0, char_ready}, 32'd1);
    rstb = 1'b0;
    step();
    check("midrst tx after", {31'd0, tx_out}, 32'd1);
    check("midrst busy after", {31'd0, busy}, 32'd0);
    check("midrst ready after", {31'd0, char_ready}, 32'd1);
    rstb = 1'b1;
    for (int i = 0; i < 3 * FRAME_CYC; i++) begin
      step();
      check("midrst line idle", {31'd0, tx_out}, 32'd1);
    end
    check("midrst busy end", {31'd0, busy}, 32'd0);
    check("midrst rx count", rx_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/char_transmitter.md
Name: char_transmitter

Overview:
- UART serializer that sits directly upstream of the XBee radio, mirroring the character receiver on the far end of the link.
- Accepts 8-bit character codes from the local Morse decoder through a valid/ready handshake and buffers them in a small FIFO.
- Drives each character onto the TX pin as 1 start bit, 8 data bits (LSB first) and 1 stop bit, at a fixed bit period in clock cycles.

Parameters:
- CLKS_PER_BIT, 10417, clock cycles per serial bit (9600 baud at 100 MHz); minimum 2.
- FIFO_DEPTH, 4, character buffer entries; power of 2, minimum 2.

Ports:
- cclk  input  1  system clock
- rstb  input  1  reset, synchronous, active-low
- char_in  input  8  character code to send (0-25 letters, 27 space, others passed unchanged)
- char_valid  input  1  char_in valid this cycle
- char_ready  output  1  FIFO can accept; equals not-full
- tx_out  output  1  serial line to radio; idles high
- busy  output  1  high while a frame is in progress or the FIFO is non-empty

Behaviour:
- Reset is sampled on posedge cclk while rstb=0. On reset: tx_out=1, busy=0, char_ready=1, FIFO emptied, FSM=IDLE, bit counter=0, cycle counter=0.
- Reset mid-frame aborts the frame. tx_out=1 from the next edge; queued characters are lost.
- Push: on each edge where char_valid && char_ready, char_in is written at the write pointer and the count increments.
- char_valid while char_ready=0 is ignored; there is no overflow or corruption.
- Pop and push in the same cycle (FIFO not full) both occur and the count is unchanged.
- Pointers are log2(FIFO_DEPTH) bits wide and wrap naturally. The count is log2(FIFO_DEPTH)+1 bits wide.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: tx_out=1. If the FIFO is non-empty, pop into the shift register, clear the cycle counter and go to START.
- START: tx_out=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: tx_out=shift[bit index], held for CLKS_PER_BIT cycles per bit. The bit index runs 0..7; after bit 7 go to STOP.
- STOP: tx_out=1 for CLKS_PER_BIT cycles.
  - At the end of STOP, if the FIFO is non-empty, pop and go directly to START, so there are no extra idle cycles between frames.
  - Otherwise go to IDLE.
- The cycle counter counts 0..CLKS_PER_BIT-1 and restarts at every bit boundary. It is not free-running, so the start edge is aligned to the pop.
- Latency: a character accepted at edge t into an empty FIFO with the FSM in IDLE drives tx_out low from edge t+2. The frame lasts 10*CLKS_PER_BIT cycles.
- tx_out is registered, so there are no combinational glitches on the pin.
- busy = (state != IDLE) || (count != 0).

Optional Feature:
- Macro CHAR_TX_STOP2_EN.
- When defined: STOP lasts 2*CLKS_PER_BIT cycles, the frame is 11 bit-times, and back-to-back START still follows immediately.
- When undefined: STOP lasts one bit-time, as above.
- Ports and parameters are identical in both builds.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3);
  - constants CHAR_SPACE=27 and default CLKS_PER_BIT=10417, shared with the receiver.
- Natural sub-module: char_fifo (synchronous FIFO with push, pop, full, empty and data out, parameterized by depth and width).
- The FSM and serializer stay in char_transmitter.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4 unless noted):
- Reset: hold rstb=0 for 3 cycles with char_valid=1 -> tx_out=1, busy=0, char_ready=1, nothing transmitted after release.
- Single char: push 8'h41 at edge t -> tx_out low from edge t+2 for 4 cycles, then data bits 1,0,0,0,0,0,1,0 at 4 cycles each, then high for 4 cycles, then busy=0.
- Back-to-back: push 8'd0, 8'd27, 8'd25 on consecutive cycles -> three 40-cycle frames with no idle gap; each stop bit's final cycle is followed directly by a start bit; decoded bytes are 0, 27, 25 in order.
- Full FIFO: push 6 chars continuously with valid held high -> char_ready drops after the 5th accepted char (1 in the shifter + 4 queued); the 6th is held and accepted only when ready rises; all 6 are sent in order with none lost.
- Mid-frame reset: assert rstb=0 during DATA bit 3 with 2 chars queued -> tx_out=1 next edge; after release, no frames are sent and busy=0.
- CHAR_TX_STOP2_EN build: two back-to-back chars -> stop interval is 8 cycles, frame period is 44 cycles.
